gray_step_arbiter: RTL and testbench



---
 rtl/gray_step_arbiter.sv | 119 +++++++++++
 tb/tb_gray_step_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/gray_step_arbiter.sv
// Round-robin arbiter sharing one 3-bit Gray step counter between two requesters.
// Optional GRAY_ABORT_EN adds an Abort input that cuts a RUN short.
module gray_step_arbiter #(
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [1:0]       Req,
    input  logic [CNT_W-1:0] Steps0,
    input  logic [CNT_W-1:0] Steps1,
`ifdef GRAY_ABORT_EN
    input  logic             Abort,
`endif
    output logic [1:0]       Grant,
    output logic             Busy,
    output logic             Done,
    output logic [2:0]       Snapshot,
    output logic             OvfSeen,
    output logic             GrayClr,
    output logic             GrayEn,
    input  logic [2:0]       GrayVal,
    input  logic             GrayOvf
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CLEAR    = 3'd1;
    localparam logic [2:0] RUN      = 3'd2;
    localparam logic [2:0] DONE     = 3'd3;
    localparam logic [2:0] WAIT_REL = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic [2:0]       snap_q, snap_d;
    logic             ovf_q, ovf_d;
    logic             sel;
    logic             abort_w;

`ifdef GRAY_ABORT_EN
    assign abort_w = Abort;
`else
    assign abort_w = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rem_d   = rem_q;
        last_d  = last_q;
        done_d  = 1'b0;
        snap_d  = snap_q;
        ovf_d   = ovf_q;
        // Contended: favour whoever was not granted last; otherwise the sole requester.
        sel     = (Req == 2'b11) ? ~last_q : Req[1];
        case (state_q)
            IDLE: begin
                if (|Req) begin
                    grant_d = sel ? 2'b10 : 2'b01;
                    last_d  = sel;
                    rem_d   = sel ? Steps1 : Steps0;
                    state_d = CLEAR;
                end
            end
            CLEAR: state_d = (rem_q != '0) ? RUN : DONE;
            RUN: begin
                if (abort_w) begin
                    state_d = DONE;
                end else begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_d = DONE;
                end
            end
            DONE: begin
                snap_d  = GrayVal;
                ovf_d   = GrayOvf;
                done_d  = 1'b1;
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if ((Req & grant_q) == 2'b00) begin
                    grant_d = 2'b00;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            rem_q   <= '0;
            last_q  <= 1'b1;
            done_q  <= 1'b0;
            snap_q  <= 3'b000;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            done_q  <= done_d;
            snap_q  <= snap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Grant    = grant_q;
    assign Busy     = (state_q != IDLE);
    assign Done     = done_q;
    assign Snapshot = snap_q;
    assign OvfSeen  = ovf_q;
    assign GrayClr  = (state_q == CLEAR);
    assign GrayEn   = (state_q == RUN) && !abort_w;

endmodule

// File: tb/tb_gray_step_arbiter.sv
// Directed bench for gray_step_arbiter with a behavioural Gray counter attached
// and a scoreboard of expected completions.
module tb_gray_step_arbiter;
    localparam int CNT_W = 4;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [1:0]       Req;
    logic [CNT_W-1:0] Steps0, Steps1;
`ifdef GRAY_ABORT_EN
    logic             Abort;
`endif
    logic [1:0]       Grant;
    logic             Busy, Done, OvfSeen, GrayClr, GrayEn, GrayOvf;
    logic [2:0]       Snapshot, GrayVal;

    gray_step_arbiter #(.CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Steps0(Steps0), .Steps1(Steps1),
`ifdef GRAY_ABORT_EN
        .Abort(Abort),
`endif
        .Grant(Grant), .Busy(Busy), .Done(Done), .Snapshot(Snapshot), .OvfSeen(OvfSeen),
        .GrayClr(GrayClr), .GrayEn(GrayEn), .GrayVal(GrayVal), .GrayOvf(GrayOvf)
    );

    always #5 Clk = ~Clk;

    // Attached counter: sync clear, overflow sticky from the 9th step after clear.
    int cnt = 0;
    always @(posedge Clk) begin
        if (GrayClr)     cnt <= 0;
        else if (GrayEn) cnt <= cnt + 1;
    end
    logic [2:0] gtab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    assign GrayVal = gtab[cnt % 8];
    assign GrayOvf = (cnt >= 9);

    typedef struct packed { logic [2:0] snap; logic ovf; } exp_t;
    exp_t sb[$];
    int errs = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_grant"}, Grant, 2'b00);
        check({tag, "_busy"}, Busy, 1'b0);
        check({tag, "_done"}, Done, 1'b0);
        check({tag, "_snap"}, Snapshot, 3'b000);
        check({tag, "_ovf"}, OvfSeen, 1'b0);
        check({tag, "_clr"}, GrayClr, 1'b0);
        check({tag, "_en"}, GrayEn, 1'b0);
    endtask

    // Called at a negedge; drives the request, follows it to Done and release.
    task automatic run(input int idx, input int n, input int abort_at, input bit hold);
        int w, cyc, en, clr, steps, lat;
        exp_t e;
        steps = (abort_at > 0) ? abort_at - 1 : n;
        lat   = (abort_at > 0) ? abort_at + 2 : n + 2;
        if (idx == 0) Steps0 = CNT_W'(n); else Steps1 = CNT_W'(n);
        Req[idx] = 1'b1;
        sb.push_back('{snap: gtab[steps % 8], ovf: (steps >= 9)});
        w = 0;
        @(negedge Clk);
        while (Grant == 2'b00 && w < 8) begin
            @(negedge Clk);
            w++;
        end
        check("grant", Grant, (idx == 1) ? 2'b10 : 2'b01);
        check("grant_lat", w, 0);
        check("busy", Busy, 1'b1);
        cyc = 0; en = 0; clr = 0;
        while (!Done && cyc < 40) begin
`ifdef GRAY_ABORT_EN
            Abort = (abort_at != 0 && cyc == abort_at);
`endif
            #1;
            en  += int'(GrayEn);
            clr += int'(GrayClr);
            @(negedge Clk);
            cyc++;
        end
`ifdef GRAY_ABORT_EN
        Abort = 1'b0;
`endif
        check("done_seen", Done, 1'b1);
        check("done_lat", cyc, lat);
        check("en_cycles", en, steps);
        check("clr_cycles", clr, 1);
        if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
            e = '0;
        end else begin
            e = sb.pop_front();
            check("snapshot", Snapshot, e.snap);
            check("ovfseen", OvfSeen, e.ovf);
        end
        if (hold) begin
            @(negedge Clk);
            check("done_pulse", Done, 1'b0);
            check("grant_held", Grant, (idx == 1) ? 2'b10 : 2'b01);
        end
        Req[idx] = 1'b0;
        @(negedge Clk);
        check("rel_grant", Grant, 2'b00);
        check("rel_busy", Busy, 1'b0);
        check("rel_done", Done, 1'b0);
        check("snap_held", Snapshot, e.snap);
    endtask

    initial begin
        int w;
        Reset = 1'b1; Req = 2'b00; Steps0 = '0; Steps1 = '0;
`ifdef GRAY_ABORT_EN
        Abort = 1'b0;
`endif
        repeat (2) @(negedge Clk);
        check_reset_vals("rst");
        Reset = 1'b0;

        run(0, 5, 0, 1'b1);
        run(0, 0, 0, 1'b0);

        // Fresh pointer, then contention: requester 0 first, then 1 after one idle cycle.
        Reset = 1'b1; @(negedge Clk); Reset = 1'b0;
        Req = 2'b10; Steps1 = 4'd7;
        run(0, 4, 0, 1'b0);
        run(1, 3, 0, 1'b0);

        run(0, 9, 0, 1'b0);
        run(0, 8, 0, 1'b0);

        // Reset two cycles into a 6-step RUN drops the sequence.
        Steps0 = 4'd6; Req = 2'b01;
        w = 0;
        @(negedge Clk);
        while (Grant == 2'b00 && w < 8) begin
            @(negedge Clk);
            w++;
        end
        check("mid_grant", Grant, 2'b01);
        repeat (2) @(negedge Clk);
        check("mid_run_en", GrayEn, 1'b1);
        Reset = 1'b1; Req = 2'b00;
        @(negedge Clk);
        check_reset_vals("mid_rst");
        Reset = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            check("mid_no_done", Done, 1'b0);
        end
        run(1, 2, 0, 1'b0);

`ifdef GRAY_ABORT_EN
        run(0, 6, 4, 1'b0);
`endif

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
